key_sched_ctrl_dec: RTL and testbench
=====================================

Name: key_sched_ctrl_dec

Overview:
- Controller that sequences the decryption key generator (key_generator_dec) through full AES-128 key expansion, using a valid/ready handshake for new cipher keys.
- After expansion, serves round-key indices to the inverse-cipher datapath in reverse order (10 down to 0), one index per advance.
- Sits between the top-level decrypt FSM / key input interface and key_generator_dec plus its round-key mux.

Parameters:
- BLOCK_LENGTH, 128, cipher key and round key width.
- NUM_ROUNDS, 10, number of expansion rounds; also the first decrypt round index.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- key_valid  input  1  new cipher key offered on key_in.
- key_in  input  BLOCK_LENGTH  cipher key.
- key_ready  output  1  controller can accept a key.
- kg_en  output  1  drives en of key_generator_dec.
- kg_key  output  BLOCK_LENGTH  registered key, drives key of key_generator_dec.
- kg_round_count  output  4  drives Round_Count of key_generator_dec.
- keys_valid  output  1  all k0..k10 hold the expansion of the current key.
- dec_start  input  1  request a decryption round sequence.
- dec_advance  input  1  datapath consumed the current index; step to the next one.
- dec_busy  output  1  decrypt sequence in progress.
- dec_round  output  4  round-key index the datapath uses (selects k10..k0).
- dec_last  output  1  dec_round==0 while busy.
- dec_done  output  1  one-cycle pulse after index 0 is consumed.

Behaviour:
- Reset values: all outputs 0, kg_key 0, state IDLE.
- Reset is asynchronous mid-operation: everything returns to IDLE and keys_valid=0. The key generator is reset by the same rst.
- States: IDLE, EXPAND, READY, DECRYPT.
- key_ready=1 only in IDLE and READY. A key is accepted when key_valid & key_ready.
- On acceptance:
  - kg_key<=key_in.
  - keys_valid<=0.
  - round counter cnt<=0.
  - go to EXPAND.
- EXPAND:
  - kg_en=1, kg_round_count=cnt, cnt increments each cycle.
  - cnt=0 is the preload cycle: the generator loads k0 and no other register is written. This is mandatory because round 1 reads the registered k0.
  - Cycles with cnt=1..NUM_ROUNDS write k1..k10.
  - Total 11 cycles of kg_en.
  - The cycle after cnt=NUM_ROUNDS: state READY, keys_valid=1, kg_en=0, kg_round_count=0.
- kg_key is held stable for the whole of EXPAND. key_valid is ignored during EXPAND.
- READY:
  - If dec_start and keys_valid: go to DECRYPT with dec_round=NUM_ROUNDS and dec_busy=1.
  - If key_valid and dec_start arrive in the same cycle, the key has priority. Go to EXPAND; dec_start is dropped and is not queued.
- IDLE: dec_start is ignored (keys_valid=0).
- DECRYPT:
  - dec_busy=1 and key_ready=0.
  - Each cycle with dec_advance=1: dec_round decrements. With dec_advance=0 it holds (stall).
  - dec_last=1 when dec_round==0.
  - dec_advance with dec_round==0: dec_done pulses for 1 cycle, dec_busy=0, go to READY, dec_round returns to 0.
- dec_round never wraps below 0.
- dec_start while already in DECRYPT is ignored.
- kg_en=0 outside EXPAND, so the generator holds its registers and keys stay stable throughout DECRYPT.
- Latency:
  - key accept to keys_valid: 12 cycles (1 accept cycle + 11 EXPAND cycles).
  - dec_start to first index: 1 cycle.
  - Full decrypt sequence with no stalls: 11 advances.

Decomposition:
- Shared package aes_dec_pkg holds:
  - state encoding (IDLE=2'd0, EXPAND=2'd1, READY=2'd2, DECRYPT=2'd3);
  - NUM_ROUNDS_128=10;
  - ROUND_CNT_W=4.
- Single module; no sub-module needed.
- Integration test instantiates key_generator_dec alongside.

Test Plan:
- Key accept → expansion: key_in=128'h000102030405060708090a0b0c0d0e0f, pulse key_valid.
  - kg_round_count sequence 0,1..10 with kg_en=1 for 11 cycles.
  - keys_valid=1 on cycle 12.
  - k10 (FIPS-197 C.1 last round key) = 13111d7fe3944a17f307a78b4d2b30c5.
- Decrypt sequence: dec_start in READY with dec_advance held 1.
  - dec_round runs 10,9,...,0, with dec_last only at 0.
  - dec_done pulses once; state returns to READY.
- Stall: dec_advance=0 for 3 cycles at dec_round=7.
  - dec_round holds at 7 and dec_busy stays 1; the sequence then resumes to 6.
- Rekey and collisions:
  - key_valid during EXPAND and DECRYPT is not accepted (key_ready=0).
  - key_valid and dec_start together in READY → EXPAND, keys_valid=0, no decrypt starts.
- Reset mid-EXPAND at cnt=5: all outputs 0 immediately (asynchronous), state IDLE. A subsequent dec_start is ignored until a new key completes expansion.
- dec_start in IDLE after reset: no response (dec_busy stays 0).

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared encodings and sizes for the AES-128 decryption key schedule controller.
package aes_dec_pkg;

  localparam int NUM_ROUNDS_128 = 10;
  localparam int ROUND_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPAND  = 2'd1,
    READY   = 2'd2,
    DECRYPT = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/key_generator_dec.sv
// AES-128 round-key generator: Round_Count 0 loads k0, Round_Count n derives kn from k(n-1).
// All round keys are kept so the inverse cipher can read them in reverse order.
module key_generator_dec
  import aes_dec_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_128
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [127:0]                          key,
  input  logic [ROUND_CNT_W-1:0]                Round_Count,
  output logic [NUM_ROUNDS:0][127:0]            round_keys
);

  localparam logic [ROUND_CNT_W-1:0] LAST_RC = ROUND_CNT_W'(NUM_ROUNDS);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from the field inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gf_mul(a, a);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_CNT_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] prev_s;
  logic [127:0] next_s;

  // Select the previous round key feeding this cycle's expansion step.
  always_comb begin
    prev_s = round_keys[0];
    if ((Round_Count != 4'd0) && (Round_Count <= LAST_RC)) begin
      prev_s = round_keys[Round_Count - 4'd1];
    end else begin
      prev_s = round_keys[0];
    end
    next_s = next_key(prev_s, rcon(Round_Count));
  end

  // Round-key storage; writes only while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_keys <= '0;
    end else if (en) begin
      if (Round_Count == 4'd0) begin
        round_keys[0] <= key;
      end else if (Round_Count <= LAST_RC) begin
        round_keys[Round_Count] <= next_s;
      end
    end
  end

endmodule

// File: rtl/key_sched_ctrl_dec.sv
// Sequences key_generator_dec through AES-128 expansion, then hands round-key
// indices NUM_ROUNDS..0 to the inverse-cipher datapath one advance at a time.
module key_sched_ctrl_dec
  import aes_dec_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int NUM_ROUNDS   = NUM_ROUNDS_128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  output logic                    key_ready,
  output logic                    kg_en,
  output logic [BLOCK_LENGTH-1:0] kg_key,
  output logic [ROUND_CNT_W-1:0]  kg_round_count,
  output logic                    keys_valid,
  input  logic                    dec_start,
  input  logic                    dec_advance,
  output logic                    dec_busy,
  output logic [ROUND_CNT_W-1:0]  dec_round,
  output logic                    dec_last,
  output logic                    dec_done
);

  localparam logic [ROUND_CNT_W-1:0] LAST_RC = ROUND_CNT_W'(NUM_ROUNDS);

  ctrl_state_t state_r;
  logic        accept_s;

  // key_ready is only ever set in IDLE/READY, so it also qualifies the state.
  assign accept_s = key_valid & key_ready;

  // Controller FSM; kg_round_count doubles as the expansion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      key_ready      <= 1'b0;
      kg_en          <= 1'b0;
      kg_key         <= '0;
      kg_round_count <= '0;
      keys_valid     <= 1'b0;
      dec_busy       <= 1'b0;
      dec_round      <= '0;
      dec_last       <= 1'b0;
      dec_done       <= 1'b0;
    end else begin
      dec_done <= 1'b0;
      if (accept_s) begin
        // A new key wins over a simultaneous dec_start, which is dropped.
        state_r        <= EXPAND;
        kg_key         <= key_in;
        keys_valid     <= 1'b0;
        kg_en          <= 1'b1;
        kg_round_count <= '0;
        key_ready      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            key_ready <= 1'b1;
          end
          EXPAND: begin
            if (kg_round_count == LAST_RC) begin
              state_r        <= READY;
              kg_en          <= 1'b0;
              kg_round_count <= '0;
              keys_valid     <= 1'b1;
              key_ready      <= 1'b1;
            end else begin
              kg_round_count <= kg_round_count + 4'd1;
            end
          end
          READY: begin
            key_ready <= 1'b1;
            if (dec_start && keys_valid) begin
              state_r   <= DECRYPT;
              dec_busy  <= 1'b1;
              dec_round <= LAST_RC;
              dec_last  <= (LAST_RC == 4'd0);
              key_ready <= 1'b0;
            end
          end
          DECRYPT: begin
            if (dec_advance) begin
              if (dec_round == 4'd0) begin
                state_r   <= READY;
                dec_done  <= 1'b1;
                dec_busy  <= 1'b0;
                dec_last  <= 1'b0;
                dec_round <= '0;
                key_ready <= 1'b1;
              end else begin
                dec_round <= dec_round - 4'd1;
                dec_last  <= (dec_round == 4'd1);
              end
            end
          end
          default: begin
            state_r        <= IDLE;
            key_ready      <= 1'b0;
            kg_en          <= 1'b0;
            kg_round_count <= '0;
            keys_valid     <= 1'b0;
            dec_busy       <= 1'b0;
            dec_round      <= '0;
            dec_last       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl_dec.sv
// Directed table-driven bench for key_sched_ctrl_dec with key_generator_dec attached.
module tb_key_sched_ctrl_dec;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ALT = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] ZK  = 128'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready;
  logic         kg_en;
  logic [127:0] kg_key;
  logic [3:0]   kg_round_count;
  logic         keys_valid;
  logic         dec_start = 1'b0;
  logic         dec_advance = 1'b0;
  logic         dec_busy;
  logic [3:0]   dec_round;
  logic         dec_last;
  logic         dec_done;
  logic [10:0][127:0] rk;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_sched_ctrl_dec dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .kg_en(kg_en), .kg_key(kg_key),
    .kg_round_count(kg_round_count), .keys_valid(keys_valid),
    .dec_start(dec_start), .dec_advance(dec_advance), .dec_busy(dec_busy),
    .dec_round(dec_round), .dec_last(dec_last), .dec_done(dec_done)
  );

  key_generator_dec kgen (
    .clk(clk), .rst(rst), .en(kg_en), .key(kg_key),
    .Round_Count(kg_round_count), .round_keys(rk)
  );

  typedef struct {
    logic kv; logic ds; logic da; logic [127:0] kin;
    logic kr; logic en; logic [3:0] rc; logic kvld;
    logic busy; logic [3:0] rnd; logic last; logic done; logic [127:0] key;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic kv, input logic ds, input logic da,
                              input logic [127:0] kin, input logic kr, input logic en,
                              input logic [3:0] rc, input logic kvld, input logic busy,
                              input logic [3:0] rnd, input logic last, input logic done,
                              input logic [127:0] key);
    vec_t v;
    v.kv = kv; v.ds = ds; v.da = da; v.kin = kin; v.kr = kr; v.en = en; v.rc = rc;
    v.kvld = kvld; v.busy = busy; v.rnd = rnd; v.last = last; v.done = done; v.key = key;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".key_ready"}, key_ready, v.kr);
    chk({tag, ".kg_en"}, kg_en, v.en);
    chk({tag, ".kg_round_count"}, kg_round_count, v.rc);
    chk({tag, ".keys_valid"}, keys_valid, v.kvld);
    chk({tag, ".dec_busy"}, dec_busy, v.busy);
    chk({tag, ".dec_round"}, dec_round, v.rnd);
    chk({tag, ".dec_last"}, dec_last, v.last);
    chk({tag, ".dec_done"}, dec_done, v.done);
    chk({tag, ".kg_key"}, kg_key, v.key);
  endtask

  initial begin
    int n;
    vec_t zero_v;

    // Main flow: idle, ignored dec_start, accept, expand, decrypt with stall, collision, partial expand.
    vecs.push_back(mk(0, 0, 0, KEY, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, ZK));
    vecs.push_back(mk(0, 1, 0, KEY, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, ZK));
    vecs.push_back(mk(1, 0, 0, KEY, 0, 1, 4'd0, 0, 0, 4'd0, 0, 0, KEY));
    for (int i = 1; i <= 10; i++)
      vecs.push_back(mk(1, 0, 0, ALT, 0, 1, 4'(i), 0, 0, 4'd0, 0, 0, KEY));
    vecs.push_back(mk(0, 0, 0, KEY, 1, 0, 4'd0, 1, 0, 4'd0, 0, 0, KEY));
    vecs.push_back(mk(0, 1, 0, KEY, 0, 0, 4'd0, 1, 1, 4'd10, 0, 0, KEY));
    vecs.push_back(mk(0, 0, 1, KEY, 0, 0, 4'd0, 1, 1, 4'd9, 0, 0, KEY));
    vecs.push_back(mk(0, 1, 1, KEY, 0, 0, 4'd0, 1, 1, 4'd8, 0, 0, KEY));
    vecs.push_back(mk(0, 0, 1, KEY, 0, 0, 4'd0, 1, 1, 4'd7, 0, 0, KEY));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, ALT, 0, 0, 4'd0, 1, 1, 4'd7, 0, 0, KEY));
    for (int r = 6; r >= 0; r--)
      vecs.push_back(mk(0, 0, 1, KEY, 0, 0, 4'd0, 1, 1, 4'(r), r == 0, 0, KEY));
    vecs.push_back(mk(0, 0, 1, KEY, 1, 0, 4'd0, 1, 0, 4'd0, 0, 1, KEY));
    vecs.push_back(mk(0, 0, 0, KEY, 1, 0, 4'd0, 1, 0, 4'd0, 0, 0, KEY));
    vecs.push_back(mk(1, 1, 0, ZK, 0, 1, 4'd0, 0, 0, 4'd0, 0, 0, ZK));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 0, 0, KEY, 0, 1, 4'(i), 0, 0, 4'd0, 0, 0, ZK));

    zero_v = mk(0, 0, 0, ZK, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, ZK);

    #12;
    chk_outs("reset", zero_v);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid   = vecs[i].kv;
      dec_start   = vecs[i].ds;
      dec_advance = vecs[i].da;
      key_in      = vecs[i].kin;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i]);
      if (vecs[i].busy && (vecs[i].rnd == 4'd10))
        chk($sformatf("vec%0d.rk_sel", i), rk[dec_round], K10);
      if (vecs[i].busy && (vecs[i].rnd == 4'd0))
        chk($sformatf("vec%0d.rk_sel", i), rk[dec_round], KEY);
    end

    // Asynchronous reset in the middle of expansion.
    key_valid = 1'b0; dec_start = 1'b0; dec_advance = 1'b0; key_in = KEY;
    #2 rst = 1'b0;
    #1;
    chk_outs("async_rst", zero_v);
    chk("async_rst.k0", rk[0], ZK);
    @(negedge clk);
    rst = 1'b1;

    dec_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_start%0d.dec_busy", i), dec_busy, 1'b0);
      chk($sformatf("idle_start%0d.keys_valid", i), keys_valid, 1'b0);
    end
    dec_start = 1'b0;

    // Fresh key: keys_valid must appear 12 edges after the accepting edge (inclusive).
    key_valid = 1'b1;
    n = 0;
    do begin
      step();
      key_valid = 1'b0;
      n++;
    end while (!keys_valid && n < 20);
    chk("accept_latency", 128'(n), 128'd12);
    chk("k0", rk[0], KEY);
    chk("k1", rk[1], K1);
    chk("k10", rk[10], K10);

    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
    chk("start_latency.dec_busy", dec_busy, 1'b1);
    chk("start_latency.dec_round", dec_round, 4'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
